// File: rtl/display_scan_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_mux_if
//  Description : Scan-strobe / digit-data inputs and display drive outputs of
//                the multiplexed 7-segment scanner, bundled as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  logic                  tick_i;
  logic                  en_i;
  logic [4*N_DIGITS-1:0] value_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic [N_DIGITS-1:0]   an_o;
  logic [6:0]            seg_o;
  logic                  dp_o;

  // Producer side: timer strobe, enable and display data; consumes the drive.
  modport master (
    output tick_i, en_i, value_i, dp_i,
    input  an_o, seg_o, dp_o
  );

  // Scanner side.
  modport slave (
    input  tick_i, en_i, value_i, dp_i,
    output an_o, seg_o, dp_o
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_mux
//  Description : Common-anode 7-segment scan multiplexer. Each scan tick
//                blanks all anodes for GUARD_CYCLES clocks, then drives the
//                next digit with its hex-decoded pattern. The displayed value
//                is snapshotted once per full scan (on wrap to digit 0).
//                Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero
//                digits (digit 0 is always shown).
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_mux_if.slave   bus
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int GRD_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [GRD_W-1:0] GUARD_LOAD = GRD_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [GRD_W-1:0]      guard_q, guard_d;
  logic [4*N_DIGITS-1:0] value_q, value_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic [3:0]            nib;
  logic                  show;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  upper_zero;
`endif

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
    endcase
  endfunction

  // Next-state logic plus the drive pattern of the next state, so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    guard_d = guard_q;
    value_d = value_q;
    dp_d    = dp_q;

    case (state_q)
      S_IDLE: begin
        if (bus.en_i) begin
          state_d = S_BLANK;
          idx_d   = '0;
          guard_d = GUARD_LOAD;
          value_d = bus.value_i;
          dp_d    = bus.dp_i;
        end
      end
      S_BLANK: begin
        // Scan ticks are ignored while the guard interval runs.
        guard_d = guard_q - 1'b1;
        if (guard_q <= GRD_W'(1)) begin
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (bus.tick_i) begin
          state_d = S_BLANK;
          guard_d = GUARD_LOAD;
          if (idx_q == LAST_IDX) begin
            // Frame boundary: take a fresh snapshot so no frame is torn.
            idx_d   = '0;
            value_d = bus.value_i;
            dp_d    = bus.dp_i;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable overrides any coincident tick.
    if (!bus.en_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end

    nib  = value_d[{idx_d, 2'b00} +: 4];
    show = (state_d == S_DRIVE);
`ifdef LEADING_ZERO_BLANK_EN
    upper_zero = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if ((k >= int'(idx_d)) && (value_d[4*k +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    if ((idx_d != '0) && upper_zero && !dp_d[idx_d]) begin
      show = 1'b0;
    end
`endif

    an_d  = '1;
    seg_d = 7'h7F;
    dpo_d = 1'b1;
    if (show) begin
      an_d[idx_d] = 1'b0;
      seg_d       = hex7(nib);
      dpo_d       = ~dp_d[idx_d];
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      guard_q <= '0;
      value_q <= '0;
      dp_q    <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dpo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
      value_q <= value_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
    end
  end

  assign bus.an_o  = an_q;
  assign bus.seg_o = seg_q;
  assign bus.dp_o  = dpo_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_mux
//  Description : Self-checking bench for display_scan_mux: vector table,
//                directed corner sequences and randomized stimulus against a
//                cycle-age reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_mux;
  localparam int N = 4;
  localparam int G = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_mux_if #(.N_DIGITS(N)) bus ();

  display_scan_mux #(.N_DIGITS(N), .GUARD_CYCLES(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                      7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                      7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [3:0] ean,
                       input logic [6:0] eseg, input logic edp);
    n_cmp++;
    if (bus.an_o !== ean || bus.seg_o !== eseg || bus.dp_o !== edp) begin
      n_bad++;
      $display("FAIL %s @%0t: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
               name, $time, bus.an_o, bus.seg_o, bus.dp_o, ean, eseg, edp);
    end
  endtask

  // ---------------- reference model: digit slot + cycles since slot start
  bit          m_on  = 1'b0;
  int          m_idx = 0;
  int          m_age = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp  = '0;

  always @(posedge clk) begin
    if (rst || !bus.en_i) begin
      m_on  <= 1'b0;
      m_idx <= 0;
    end else if (!m_on) begin
      m_on  <= 1'b1;
      m_idx <= 0;
      m_age <= 0;
      m_val <= bus.value_i;
      m_dp  <= bus.dp_i;
    end else if (m_age >= G && bus.tick_i) begin
      m_idx <= (m_idx + 1) % N;
      m_age <= 0;
      if ((m_idx + 1) % N == 0) begin
        m_val <= bus.value_i;
        m_dp  <= bus.dp_i;
      end
    end else if (m_age < 1000) begin
      m_age <= m_age + 1;
    end
  end

  // Every cycle: outputs against the model, and at most one anode low.
  always @(negedge clk) begin
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    logic [15:0] upper;
    if (chk_on) begin
      ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
      if (m_on && m_age >= G) begin
        upper = m_val >> (4 * m_idx);
        if (!(LZ_ON && m_idx > 0 && upper == 16'h0 && !m_dp[m_idx])) begin
          ean  = ~(4'b0001 << m_idx);
          eseg = HEX[upper[3:0]];
          edp  = ~m_dp[m_idx];
        end
      end
      check("model", ean, eseg, edp);
      n_cmp++;
      if ($countones(~bus.an_o) > 1) begin
        n_bad++;
        $display("FAIL onehot @%0t: got an=%b, want at most one low bit", $time, bus.an_o);
      end
    end
  end

  // ---------------- vector table
  typedef struct packed {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic [3:0][6:0] seg;   // expected pattern per digit, [0] = rightmost
    logic [3:0]      lz;    // digits dark when leading-zero blanking is built in
  } vec_t;

  vec_t tbl [5];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
  endtask

  task automatic check_digit(input string name, input vec_t e, input int d);
    if (LZ_ON && e.lz[d])
      check(name, 4'hF, 7'h7F, 1'b1);
    else
      check(name, ~(4'b0001 << d), e.seg[d], ~e.dp[d]);
  endtask

  task automatic restart(input logic [15:0] v, input logic [3:0] p);
    bus.en_i = 1'b0;
    cyc(1);
    bus.value_i = v;
    bus.dp_i    = p;
    bus.en_i    = 1'b1;
    cyc(G + 1);
  endtask

  initial begin
    logic [15:0] rv;
    tbl[0] = '{val:16'h12AF, dp:4'b0000, seg:{7'h79, 7'h24, 7'h08, 7'h0E}, lz:4'b0000};
    tbl[1] = '{val:16'h0050, dp:4'b0000, seg:{7'h40, 7'h40, 7'h12, 7'h40}, lz:4'b1100};
    tbl[2] = '{val:16'h3C0D, dp:4'b0101, seg:{7'h30, 7'h46, 7'h40, 7'h21}, lz:4'b0000};
    tbl[3] = '{val:16'h0000, dp:4'b0100, seg:{7'h40, 7'h40, 7'h40, 7'h40}, lz:4'b1010};
    tbl[4] = '{val:16'h8E69, dp:4'b1000, seg:{7'h00, 7'h06, 7'h02, 7'h10}, lz:4'b0000};

    rst = 1'b1;
    bus.tick_i = 1'b0; bus.en_i = 1'b0; bus.value_i = '0; bus.dp_i = '0;
    cyc(3);
    chk_on = 1'b1;
    check("reset", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;
    cyc(2);
    check("idle", 4'hF, 7'h7F, 1'b1);

    // Table: full scan of each vector including the guard and the wrap.
    for (int i = 0; i < 5; i++) begin
      restart(tbl[i].val, tbl[i].dp);
      check_digit("vec_d0", tbl[i], 0);
      for (int d = 1; d <= N; d++) begin
        do_tick();
        check("guard_start", 4'hF, 7'h7F, 1'b1);
        cyc(G - 1);
        check("guard_end", 4'hF, 7'h7F, 1'b1);
        cyc(1);
        check_digit("vec_digit", tbl[i], d % N);
      end
    end

    // Tick during BLANK is ignored: digit advances by exactly one.
    restart(16'h12AF, 4'b0000);
    do_tick();
    cyc(2);
    do_tick();
    cyc(G - 3);
    check("tick_in_blank", 4'b1101, 7'h08, 1'b1);

    // Value change mid-frame takes effect only at the wrap.
    restart(16'h12AF, 4'b0000);
    do_tick(); cyc(G);
    check("mid_d1", 4'b1101, 7'h08, 1'b1);
    bus.value_i = 16'h0000;
    do_tick(); cyc(G);
    check("mid_d2_old", 4'b1011, 7'h24, 1'b1);
    do_tick(); cyc(G);
    check("mid_d3_old", 4'b0111, 7'h79, 1'b1);
    do_tick(); cyc(G);
    check("wrap_d0_new", 4'b1110, 7'h40, 1'b1);
    do_tick(); cyc(G);
    if (LZ_ON) check("wrap_d1_new", 4'hF, 7'h7F, 1'b1);
    else       check("wrap_d1_new", 4'b1101, 7'h40, 1'b1);

    // en_i drop coincident with a tick during digit 2.
    restart(16'h12AF, 4'b0000);
    do_tick(); cyc(G);
    do_tick(); cyc(G);
    check("pre_disable_d2", 4'b1011, 7'h24, 1'b1);
    bus.tick_i = 1'b1; bus.en_i = 1'b0;
    @(negedge clk);
    bus.tick_i = 1'b0;
    check("disable_next", 4'hF, 7'h7F, 1'b1);
    cyc(3);
    check("disable_hold", 4'hF, 7'h7F, 1'b1);
    bus.en_i = 1'b1;
    cyc(G);
    check("reenable_guard", 4'hF, 7'h7F, 1'b1);
    cyc(1);
    check("reenable_d0", 4'b1110, 7'h0E, 1'b1);

    // Reset in the middle of a guard interval.
    do_tick();
    cyc(3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_blank", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;
    cyc(G);
    check("post_rst_guard", 4'hF, 7'h7F, 1'b1);
    cyc(1);
    check("post_rst_d0", 4'b1110, 7'h0E, 1'b1);

    // Randomized traffic checked continuously by the model.
    for (int c = 0; c < 4000; c++) begin
      bus.tick_i = ($urandom_range(99, 0) < 5);
      bus.en_i   = ($urandom_range(299, 0) != 0);
      rst        = ($urandom_range(499, 0) == 0);
      if ($urandom_range(19, 0) == 0) begin
        rv = '0;
        for (int k = 0; k < N; k++)
          if ($urandom_range(1, 0) == 1) rv[4*k +: 4] = 4'($urandom_range(15, 0));
        bus.value_i = rv;
        bus.dp_i    = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'h0;
      end
      @(negedge clk);
    end
    bus.tick_i = 1'b0;
    rst = 1'b0;
    bus.en_i = 1'b0;
    cyc(2);
    check("final_idle", 4'hF, 7'h7F, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
